snake_controller: RTL and testbench

Sequencing controller for the snake engine's body shift-register chain. Paces the game with a tick timer, computes the next head position from the latched direction, and scans the body chain through a registered read port for self-collision. On a clean move it issues the one-cycle enable that advances every body segment, and handles growth on food, wall and self collision, and game-over/restart. Sits between the input/direction logic, the food generator and the chain of body segment registers.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_tick_timer.sv | 33 +++
 rtl/snake_controller.sv | 196 +++++++++++++++++++
 tb/tb_snake_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake engine controller.
package snake_pkg;

  localparam int unsigned COORD_W = 5;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRunWait,
    StCalc,
    StScan,
    StCommit,
    StOver
  } state_e;

  // Opposite directions differ only in the top bit of the encoding.
  function automatic logic [1:0] dir_opposite(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_tick_timer.sv
// Move-pacing counter: counts while clr is low and flags done on its last cycle.
module snake_tick_timer #(
  parameter int unsigned TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_controller.sv
// Snake move sequencer: paces moves, computes the next head, scans the body
// chain for self-collision and drives the chain shift/reload pulses.
module snake_controller
  import snake_pkg::*;
#(
  parameter int unsigned GRID        = 20,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned INIT_LEN    = 3,
  parameter int unsigned TICK_CYCLES = 5_000_000,
  parameter int unsigned START_X     = 10,
  parameter int unsigned START_Y     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 dir_req,
  input  logic                       dir_valid,
  input  logic [4:0]                 food_x,
  input  logic [4:0]                 food_y,
  input  logic [4:0]                 body_rd_x,
  input  logic [4:0]                 body_rd_y,
  output logic [$clog2(MAX_LEN)-1:0] body_rd_idx,
  output logic                       shift_en,
  output logic                       body_init,
  output logic [4:0]                 head_x,
  output logic [4:0]                 head_y,
  output logic [4:0]                 length,
  output logic                       food_eaten,
  output logic                       game_over,
  output logic                       busy
);

  localparam int unsigned IdxW = $clog2(MAX_LEN);
  localparam logic [COORD_W-1:0] GridMax = COORD_W'(GRID - 1);
  localparam logic [COORD_W-1:0] StartX  = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] StartY  = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] InitLen = COORD_W'(INIT_LEN);
  localparam logic [COORD_W-1:0] MaxLen  = COORD_W'(MAX_LEN);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   head_x_q, head_x_d, head_y_q, head_y_d;
  logic [COORD_W-1:0]   nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
  logic [COORD_W-1:0]   len_q, len_d;
  logic [COORD_W-1:0]   scan_n_q, scan_n_d, scan_c_q, scan_c_d;
  logic [1:0]           dir_q, dir_d, pend_q, pend_d;
  logic                 grow_q, grow_d, hit_q, hit_d;

  logic                 tick_clr, tick_done;
  logic                 dir_ok, wall, hit_c, grow_c;
  logic [1:0]           dir_eff;
  logic [COORD_W-1:0]   cand_x, cand_y;

  snake_tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .done(tick_done)
  );

  // Candidate head from the direction that CALC would commit this cycle.
  always_comb begin
    dir_ok  = dir_valid && (dir_req != dir_opposite(dir_q));
    dir_eff = dir_ok ? dir_req : pend_q;
    cand_x  = head_x_q;
    cand_y  = head_y_q;
    wall    = 1'b0;
    unique case (dir_eff)
      DIR_UP:    begin wall = (head_y_q == '0);      cand_y = head_y_q - COORD_W'(1); end
      DIR_RIGHT: begin wall = (head_x_q == GridMax); cand_x = head_x_q + COORD_W'(1); end
      DIR_DOWN:  begin wall = (head_y_q == GridMax); cand_y = head_y_q + COORD_W'(1); end
      DIR_LEFT:  begin wall = (head_x_q == '0);      cand_x = head_x_q - COORD_W'(1); end
    endcase
    hit_c  = (cand_x == food_x) && (cand_y == food_y);
    grow_c = hit_c && (len_q < MaxLen);
  end

  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    nxt_x_d     = nxt_x_q;
    nxt_y_d     = nxt_y_q;
    len_d       = len_q;
    scan_n_d    = scan_n_q;
    scan_c_d    = scan_c_q;
    dir_d       = dir_q;
    pend_d      = dir_ok ? dir_req : pend_q;
    grow_d      = grow_q;
    hit_d       = hit_q;
    tick_clr    = 1'b1;
    shift_en    = 1'b0;
    body_init   = 1'b0;
    food_eaten  = 1'b0;
    body_rd_idx = '0;

    case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d   = StRunWait;
          body_init = 1'b1;
          head_x_d  = StartX;
          head_y_d  = StartY;
          dir_d     = DIR_RIGHT;
          pend_d    = DIR_RIGHT;
          len_d     = InitLen;
        end
      end
      StRunWait: begin
        tick_clr = 1'b0;
        if (tick_done) state_d = StCalc;
      end
      StCalc: begin
        dir_d    = dir_eff;
        nxt_x_d  = cand_x;
        nxt_y_d  = cand_y;
        grow_d   = grow_c;
        hit_d    = hit_c;
        // Without growth the tail cell is vacated by the shift, so skip it.
        scan_n_d = grow_c ? len_q : len_q - COORD_W'(1);
        scan_c_d = '0;
        if (wall) begin
          state_d = StOver;
        end else if (scan_n_d == '0) begin
          state_d = StCommit;
        end else begin
          state_d = StScan;
        end
      end
      StScan: begin
        // scan_c_q counts issued indices; the sample for index c-1 arrives now.
        if (scan_c_q < scan_n_q) body_rd_idx = scan_c_q[IdxW-1:0];
        if ((scan_c_q != '0) && (body_rd_x == nxt_x_q) && (body_rd_y == nxt_y_q)) begin
          state_d = StOver;
        end else if (scan_c_q == scan_n_q) begin
          state_d = StCommit;
        end else begin
          scan_c_d = scan_c_q + COORD_W'(1);
        end
      end
      StCommit: begin
        shift_en   = 1'b1;
        food_eaten = hit_q;
        head_x_d   = nxt_x_q;
        head_y_d   = nxt_y_q;
        if (grow_q) len_d = len_q + COORD_W'(1);
        state_d    = StRunWait;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      shift_en   = 1'b0;
      body_init  = 1'b0;
      food_eaten = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      head_x_q <= StartX;
      head_y_q <= StartY;
      nxt_x_q  <= StartX;
      nxt_y_q  <= StartY;
      len_q    <= InitLen;
      scan_n_q <= '0;
      scan_c_q <= '0;
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      grow_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      nxt_x_q  <= nxt_x_d;
      nxt_y_q  <= nxt_y_d;
      len_q    <= len_d;
      scan_n_q <= scan_n_d;
      scan_c_q <= scan_c_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      grow_q   <= grow_d;
      hit_q    <= hit_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = len_q;
  assign game_over = (state_q == StOver);
  assign busy      = (state_q == StCalc) || (state_q == StScan) || (state_q == StCommit);

endmodule

// File: tb/tb_snake_controller.sv
// Directed bench for snake_controller with a behavioural body-chain model.
module tb_snake_controller;

  localparam int unsigned MaxLen = 16;

  logic       clk = 1'b0;
  logic       rst, start, dir_valid;
  logic [1:0] dir_req;
  logic [4:0] food_x, food_y, body_rd_x, body_rd_y;
  logic [3:0] body_rd_idx;
  logic       shift_en, body_init, food_eaten, game_over, busy;
  logic [4:0] head_x, head_y, length;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_shift = 0;

  typedef struct {
    logic       d1v;
    logic [1:0] d1;
    logic       d2v;
    logic [1:0] d2;
    int         fx, fy;
    int         ex, ey, elen, eaten, eper;
  } move_t;

  move_t tbl[10];

  logic [4:0] bx[MaxLen];
  logic [4:0] by[MaxLen];

  snake_controller #(
    .GRID(20), .MAX_LEN(16), .INIT_LEN(3), .TICK_CYCLES(4), .START_X(10), .START_Y(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir_req(dir_req), .dir_valid(dir_valid),
    .food_x(food_x), .food_y(food_y), .body_rd_x(body_rd_x), .body_rd_y(body_rd_y),
    .body_rd_idx(body_rd_idx), .shift_en(shift_en), .body_init(body_init),
    .head_x(head_x), .head_y(head_y), .length(length), .food_eaten(food_eaten),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  // Body chain: initial layout trails to the left of the start cell.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MaxLen; i++) begin bx[i] <= 5'd31; by[i] <= 5'd31; end
    end else if (body_init) begin
      for (int i = 0; i < MaxLen; i++) begin
        bx[i] <= (i < 3) ? 5'(9 - i) : 5'd31;
        by[i] <= (i < 3) ? 5'd10 : 5'd31;
      end
    end else if (shift_en) begin
      bx[0] <= head_x;
      by[0] <= head_y;
      for (int i = 1; i < MaxLen; i++) begin bx[i] <= bx[i-1]; by[i] <= by[i-1]; end
    end
    body_rd_x <= bx[body_rd_idx];
    body_rd_y <= by[body_rd_idx];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_move(input move_t m);
    food_x = 5'(m.fx);
    food_y = 5'(m.fy);
    if (m.d1v) begin dir_req = m.d1; dir_valid = 1'b1; tick(); dir_valid = 1'b0; end
    if (m.d2v) begin dir_req = m.d2; dir_valid = 1'b1; tick(); dir_valid = 1'b0; end
    for (int k = 0; k < 100 && !shift_en && !game_over; k++) tick();
    chk("move_shift_en", int'(shift_en), 1);
    chk("move_food_eaten", int'(food_eaten), m.eaten);
    if (m.eper != 0) chk("move_period", cyc - last_shift, m.eper);
    last_shift = cyc;
    tick();
    chk("move_head_x", int'(head_x), m.ex);
    chk("move_head_y", int'(head_y), m.ey);
    chk("move_length", int'(length), m.elen);
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    chk("start_body_init", int'(body_init), 1);
    tick();
    start = 1'b0;
    chk("start_game_over", int'(game_over), 0);
    chk("start_head_x", int'(head_x), 10);
    chk("start_head_y", int'(head_y), 10);
    chk("start_length", int'(length), 3);
    chk("start_body_init_off", int'(body_init), 0);
  endtask

  initial begin
    int busy_cnt, max_idx, shifts;
    //        d1v  d1     d2v  d2     fx  fy  ex  ey len eat per
    tbl[0] = '{1'b0, 2'b00, 1'b0, 2'b00, 0,  0, 11, 10, 3, 0, 0};
    tbl[1] = '{1'b0, 2'b00, 1'b0, 2'b00, 12, 10, 12, 10, 4, 1, 10};
    tbl[2] = '{1'b1, 2'b11, 1'b1, 2'b00, 0,  0, 12,  9, 4, 0, 10};
    tbl[3] = '{1'b1, 2'b11, 1'b0, 2'b00, 0,  0, 11,  9, 4, 0, 10};
    tbl[4] = '{1'b1, 2'b01, 1'b0, 2'b00, 0,  0, 10,  9, 4, 0, 10};
    tbl[5] = '{1'b1, 2'b10, 1'b0, 2'b00, 0,  0, 10, 10, 4, 0, 10};
    tbl[6] = '{1'b1, 2'b01, 1'b0, 2'b00, 0,  0, 11, 10, 4, 0, 10};
    tbl[7] = '{1'b1, 2'b00, 1'b0, 2'b00, 0,  0, 10,  9, 3, 0, 0};
    tbl[8] = '{1'b1, 2'b11, 1'b0, 2'b00, 0,  0,  9,  9, 3, 0, 9};
    tbl[9] = '{1'b1, 2'b10, 1'b0, 2'b00, 0,  0,  9, 10, 3, 0, 9};

    rst = 1'b1; start = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
    food_x = 5'd0; food_y = 5'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_head_x", int'(head_x), 10);
    chk("rst_head_y", int'(head_y), 10);
    chk("rst_length", int'(length), 3);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_idx", int'(body_rd_idx), 0);

    do_start();
    for (int i = 0; i < 7; i++) do_move(tbl[i]);

    // Heading up into (11,9), which sits at body index 2.
    dir_req = 2'b00; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    busy_cnt = 0; max_idx = 0; shifts = 0;
    for (int k = 0; k < 100 && !game_over; k++) begin
      if (busy) busy_cnt++;
      if (int'(body_rd_idx) > max_idx) max_idx = int'(body_rd_idx);
      if (shift_en) shifts++;
      tick();
    end
    chk("self_game_over", int'(game_over), 1);
    chk("self_busy_cycles", busy_cnt, 5);
    chk("self_max_idx", max_idx, 2);
    chk("self_no_shift", shifts, 0);
    repeat (12) begin
      if (shift_en) shifts++;
      tick();
    end
    chk("over_no_shift", shifts, 0);
    chk("over_head_x", int'(head_x), 11);
    chk("over_head_y", int'(head_y), 10);
    chk("over_length", int'(length), 4);

    do_start();
    last_shift = cyc;
    for (int i = 7; i < 10; i++) do_move(tbl[i]);
    chk("tail_no_collision", int'(game_over), 0);

    // Keep heading down from (9,10) until the bottom wall ends the game.
    busy_cnt = 0; shifts = 0;
    for (int k = 0; k < 300 && !game_over; k++) begin
      if (shift_en) begin shifts++; busy_cnt = 0; end
      else if (busy) busy_cnt++;
      tick();
    end
    chk("wall_game_over", int'(game_over), 1);
    chk("wall_moves", shifts, 9);
    chk("wall_busy_cycles", busy_cnt, 1);
    chk("wall_head_x", int'(head_x), 9);
    chk("wall_head_y", int'(head_y), 19);
    do_start();

    // One clean move, then reset in the first SCAN cycle of the next.
    for (int k = 0; k < 100 && !shift_en; k++) tick();
    tick();
    chk("pre_rst_head_x", int'(head_x), 11);
    for (int k = 0; k < 100 && !busy; k++) tick();
    tick();
    chk("scan_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("scan_rst_shift", int'(shift_en), 0);
    tick();
    rst = 1'b0;
    chk("scan_rst_head_x", int'(head_x), 10);
    chk("scan_rst_length", int'(length), 3);
    chk("scan_rst_busy", int'(busy), 0);
    chk("scan_rst_game_over", int'(game_over), 0);
    chk("scan_rst_idx", int'(body_rd_idx), 0);
    shifts = 0; busy_cnt = 0;
    repeat (15) begin
      if (shift_en) shifts++;
      if (busy) busy_cnt++;
      tick();
    end
    chk("idle_no_shift", shifts, 0);
    chk("idle_no_busy", busy_cnt, 0);

    // Reset landing on a COMMIT cycle suppresses the shift pulse.
    do_start();
    for (int k = 0; k < 100 && !shift_en; k++) tick();
    rst = 1'b1;
    #1;
    chk("commit_rst_shift", int'(shift_en), 0);
    tick();
    rst = 1'b0;
    chk("commit_rst_head_x", int'(head_x), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
